// File: rtl/arrow_tracker_multi.sv
// rtl/arrow_tracker_multi.sv - multi-channel arrow flight/hit timer with saturating hit counter
// Each channel latches the target aim on a shot, evaluates after a flight time, then runs hit/show/cool phases.

module arrow_tracker_multi #(
   parameter int N_CH       = 4,
   parameter int COORD_W    = 16,
   parameter int CMP_W      = 8,
   parameter int TOL        = 0,
   parameter int FLIGHT_CYC = 15000000,
   parameter int HIT_CYC    = 10000000,
   parameter int SHOW_CYC   = 2000000,
   parameter int COOL_CYC   = 1,
   parameter int CNT_W      = 8,
   localparam int ID_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               alive,
   input  logic [N_CH-1:0]    who_shoot,
   input  logic [COORD_W-1:0] target_x,
   input  logic [COORD_W-1:0] target_y,
   output logic [N_CH-1:0]    arrow,
   output logic [N_CH-1:0]    hit,
   output logic               any_hit,
   output logic [ID_W-1:0]    hit_id,
   output logic [N_CH-1:0]    busy,
   output logic [CNT_W-1:0]   hit_count
);

   localparam int MAX_FH  = (FLIGHT_CYC > HIT_CYC) ? FLIGHT_CYC : HIT_CYC;
   localparam int MAX_SC  = (SHOW_CYC > COOL_CYC) ? SHOW_CYC : COOL_CYC;
   localparam int MAX_CYC = (MAX_FH > MAX_SC) ? MAX_FH : MAX_SC;
   localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int PW      = $clog2(N_CH + 1);
   localparam int SW      = CNT_W + PW;

   localparam logic [CW-1:0]    FL_LD   = CW'(FLIGHT_CYC - 1);
   localparam logic [CW-1:0]    HT_LD   = CW'(HIT_CYC - 1);
   localparam logic [CW-1:0]    SH_LD   = CW'(SHOW_CYC - 1);
   localparam logic [CW-1:0]    CL_LD   = CW'(COOL_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {S_IDLE, S_FLIGHT, S_HIT, S_SHOW, S_COOL} state_t;

   logic [CMP_W-1:0] ax_now;
   logic [CMP_W-1:0] ay_now;
   logic [N_CH-1:0]  enter_hit;

   assign ax_now = target_x[COORD_W-1 -: CMP_W];
   assign ay_now = target_y[COORD_W-1 -: CMP_W];

   if (CMP_W < COORD_W) begin : g_unused
      logic unused_lsb;
      assign unused_lsb = ^{target_x[COORD_W-CMP_W-1:0], target_y[COORD_W-CMP_W-1:0]};
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      state_t           state_q;
      logic [CW-1:0]    cnt_q;
      logic [CMP_W-1:0] aim_x_q;
      logic [CMP_W-1:0] aim_y_q;
      logic             hit_q;
      logic             arrow_q;
      logic             busy_q;
      logic [CMP_W-1:0] dx;
      logic [CMP_W-1:0] dy;
      logic             match;

      // Unsigned distance without wrap, so 0x00 and 0xFF are far apart.
      assign dx    = (ax_now >= aim_x_q) ? ax_now - aim_x_q : aim_x_q - ax_now;
      assign dy    = (ay_now >= aim_y_q) ? ay_now - aim_y_q : aim_y_q - ay_now;
      assign match = (int'(dx) <= TOL) && (int'(dy) <= TOL);

      assign enter_hit[i] = (state_q == S_FLIGHT) && alive && (cnt_q == '0) && match;
      assign hit[i]       = hit_q;
      assign arrow[i]     = arrow_q;
      assign busy[i]      = busy_q;

      always_ff @(posedge Clk) begin
         if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            aim_x_q <= '0;
            aim_y_q <= '0;
            hit_q   <= 1'b0;
            arrow_q <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            hit_q   <= (state_q == S_HIT);
            arrow_q <= (state_q == S_HIT) || (state_q == S_SHOW);
            busy_q  <= (state_q != S_IDLE);
            case (state_q)
               S_IDLE: begin
                  if (who_shoot[i] && alive) begin
                     aim_x_q <= ax_now;
                     aim_y_q <= ay_now;
                     cnt_q   <= FL_LD;
                     state_q <= S_FLIGHT;
                  end
               end
               S_FLIGHT: begin
                  if (!alive) begin
                     state_q <= S_IDLE;
                  end else if (cnt_q == '0) begin
                     if (match) begin
                        cnt_q   <= HT_LD;
                        state_q <= S_HIT;
                     end else begin
                        cnt_q   <= CL_LD;
                        state_q <= S_COOL;
                     end
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
               S_HIT: begin
                  if (cnt_q == '0) begin
                     cnt_q   <= SH_LD;
                     state_q <= S_SHOW;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
               S_SHOW: begin
                  if (cnt_q == '0) begin
                     cnt_q   <= CL_LD;
                     state_q <= S_COOL;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
               S_COOL: begin
                  if (cnt_q == '0) begin
                     state_q <= S_IDLE;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   logic [PW-1:0]    pop;
   logic [SW-1:0]    sum;
   logic [CNT_W-1:0] hit_count_q;
   logic [CNT_W-1:0] hit_count_d;

   always_comb begin
      pop = '0;
      for (int i = 0; i < N_CH; i++) begin
         pop = pop + PW'(enter_hit[i]);
      end
      sum         = SW'(hit_count_q) + SW'(pop);
      hit_count_d = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         hit_count_q <= '0;
      end else begin
         hit_count_q <= hit_count_d;
      end
   end

   assign hit_count = hit_count_q;

   always_comb begin
      hit_id = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (hit[i]) hit_id = ID_W'(i);
      end
   end

   assign any_hit = |hit;

endmodule

// File: tb/tb_arrow_tracker_multi.sv
// tb/tb_arrow_tracker_multi.sv - randomized and directed bench for arrow_tracker_multi against an interval-based model
// Two instances share stimulus: exact aim with wide counter, and tolerance 1 with a 2-bit counter.

module tb_arrow_tracker_multi;

   localparam int F = 4;
   localparam int H = 3;
   localparam int S = 2;
   localparam int C = 1;
   localparam int BIG = 32'h3fffffff;

   logic        Clk;
   logic        Reset_n;
   logic        alive;
   logic [3:0]  who_shoot;
   logic [15:0] target_x;
   logic [15:0] target_y;

   logic [3:0] arrow0, hit0, busy0, arrow1, hit1, busy1;
   logic       any0, any1;
   logic [1:0] id0, id1;
   logic [7:0] cnt0;
   logic [1:0] cnt1;

   arrow_tracker_multi #(
      .N_CH(4), .COORD_W(16), .CMP_W(8), .TOL(0), .FLIGHT_CYC(F), .HIT_CYC(H),
      .SHOW_CYC(S), .COOL_CYC(C), .CNT_W(8)
   ) u0 (
      .Clk(Clk), .Reset_n(Reset_n), .alive(alive), .who_shoot(who_shoot),
      .target_x(target_x), .target_y(target_y), .arrow(arrow0), .hit(hit0),
      .any_hit(any0), .hit_id(id0), .busy(busy0), .hit_count(cnt0)
   );

   arrow_tracker_multi #(
      .N_CH(4), .COORD_W(16), .CMP_W(8), .TOL(1), .FLIGHT_CYC(F), .HIT_CYC(H),
      .SHOW_CYC(S), .COOL_CYC(C), .CNT_W(2)
   ) u1 (
      .Clk(Clk), .Reset_n(Reset_n), .alive(alive), .who_shoot(who_shoot),
      .target_x(target_x), .target_y(target_y), .arrow(arrow1), .hit(hit1),
      .any_hit(any1), .hit_id(id1), .busy(busy1), .hit_count(cnt1)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Model: each shot resolves into fixed edge intervals for hit, arrow and busy.
   int m_start [2][4];
   int m_bl    [2][4];
   int m_hs    [2][4];
   int m_he    [2][4];
   int m_ae    [2][4];
   int m_ax    [2][4];
   int m_ay    [2][4];
   bit m_fl    [2][4];
   bit m_hv    [2][4];
   int m_cnt   [2];
   int ecur = 0;

   task automatic model_edge(input int k, input int e, input bit rn, input bit al,
                             input logic [3:0] sh, input logic [15:0] x, input logic [15:0] y);
      int tol, sat, axn, ayn, dx, dy;
      tol = (k == 1) ? 1 : 0;
      sat = (k == 1) ? 3 : 255;
      axn = int'(x[15:8]);
      ayn = int'(y[15:8]);
      if (!rn) begin
         m_cnt[k] = 0;
         for (int ch = 0; ch < 4; ch++) begin
            m_fl[k][ch] = 0; m_hv[k][ch] = 0; m_start[k][ch] = e; m_bl[k][ch] = e;
         end
      end else begin
         for (int ch = 0; ch < 4; ch++) begin
            if (m_fl[k][ch]) begin
               if (!al) begin
                  m_fl[k][ch] = 0;
                  m_bl[k][ch] = e;
               end else if (e == m_start[k][ch] + F) begin
                  m_fl[k][ch] = 0;
                  dx = (axn > m_ax[k][ch]) ? axn - m_ax[k][ch] : m_ax[k][ch] - axn;
                  dy = (ayn > m_ay[k][ch]) ? ayn - m_ay[k][ch] : m_ay[k][ch] - ayn;
                  if (dx <= tol && dy <= tol) begin
                     m_hv[k][ch] = 1;
                     m_hs[k][ch] = e + 1;
                     m_he[k][ch] = e + H;
                     m_ae[k][ch] = e + H + S;
                     m_bl[k][ch] = e + H + S + C;
                     if (m_cnt[k] < sat) m_cnt[k]++;
                  end else begin
                     m_bl[k][ch] = e + C;
                  end
               end
            end else if (e > m_bl[k][ch] && sh[ch] && al) begin
               m_fl[k][ch]    = 1;
               m_hv[k][ch]    = 0;
               m_start[k][ch] = e;
               m_bl[k][ch]    = BIG;
               m_ax[k][ch]    = axn;
               m_ay[k][ch]    = ayn;
            end
         end
      end
   endtask

   task automatic check_outputs(input int k, input int e);
      logic [3:0] eh, ea, eb, oh, oa, ob;
      logic [1:0] eid;
      eid = 2'd0;
      for (int ch = 0; ch < 4; ch++) begin
         eh[ch] = m_hv[k][ch] && (m_hs[k][ch] <= e) && (e <= m_he[k][ch]);
         ea[ch] = m_hv[k][ch] && (m_hs[k][ch] <= e) && (e <= m_ae[k][ch]);
         eb[ch] = (m_start[k][ch] + 1 <= e) && (e <= m_bl[k][ch]);
      end
      for (int ch = 3; ch >= 0; ch--) if (eh[ch]) eid = 2'(ch);
      oh = (k == 1) ? hit1 : hit0;
      oa = (k == 1) ? arrow1 : arrow0;
      ob = (k == 1) ? busy1 : busy0;
      chk($sformatf("u%0d_hit@%0d", k, e), 32'(oh), 32'(eh));
      chk($sformatf("u%0d_arrow@%0d", k, e), 32'(oa), 32'(ea));
      chk($sformatf("u%0d_busy@%0d", k, e), 32'(ob), 32'(eb));
      chk($sformatf("u%0d_any_hit@%0d", k, e), 32'((k == 1) ? any1 : any0), 32'(|eh));
      chk($sformatf("u%0d_hit_id@%0d", k, e), 32'((k == 1) ? id1 : id0), 32'(eid));
      chk($sformatf("u%0d_hit_count@%0d", k, e), (k == 1) ? 32'(cnt1) : 32'(cnt0), 32'(m_cnt[k]));
   endtask

   logic [15:0] cur_x = 16'h1234;
   logic [15:0] cur_y = 16'h5678;
   int   h0_cyc, a0_cyc, rise0, anyc;
   logic prev_h0;

   task automatic cyc(input bit rn, input bit al, input logic [3:0] sh);
      @(negedge Clk);
      Reset_n = rn; alive = al; who_shoot = sh; target_x = cur_x; target_y = cur_y;
      @(posedge Clk);
      model_edge(0, ecur, rn, al, sh, cur_x, cur_y);
      model_edge(1, ecur, rn, al, sh, cur_x, cur_y);
      #1;
      check_outputs(0, ecur);
      check_outputs(1, ecur);
      if (hit0[0]) h0_cyc++;
      if (arrow0[0]) a0_cyc++;
      if (hit0[0] && !prev_h0) rise0++;
      if (any0 || any1) anyc++;
      prev_h0 = hit0[0];
      ecur++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 4'b0000);
   endtask

   task automatic clr_stats();
      h0_cyc = 0; a0_cyc = 0; rise0 = 0; anyc = 0;
   endtask

   initial begin
      Reset_n = 1'b0; alive = 1'b0; who_shoot = '0; target_x = '0; target_y = '0;
      prev_h0 = 1'b0;
      clr_stats();
      cyc(1'b0, 1'b1, 4'b0000);
      cyc(1'b0, 1'b1, 4'b0000);
      chk("reset_count", 32'(cnt0), 32'd0);
      chk("reset_busy", 32'(busy0 | busy1), 32'd0);

      // Single hit on a stationary target.
      idle(2);
      clr_stats();
      cyc(1'b1, 1'b1, 4'b0001);
      idle(12);
      chk("single_hit_len", 32'(h0_cyc), 32'd3);
      chk("single_arrow_len", 32'(a0_cyc), 32'd5);
      chk("single_count", 32'(cnt0), 32'd1);

      // Target drifts two steps before evaluation: miss for both tolerances.
      cur_x = 16'h10AB;
      cyc(1'b1, 1'b1, 4'b0001);
      cur_x = 16'h12CD;
      idle(12);
      chk("tol_far_u1", 32'(cnt1), 32'd1);
      // One step: inside tolerance 1 only.
      cur_x = 16'h10AB;
      cyc(1'b1, 1'b1, 4'b0001);
      cur_x = 16'h1100;
      idle(12);
      chk("tol_near_u1", 32'(cnt1), 32'd2);
      chk("tol_near_u0", 32'(cnt0), 32'd1);
      // 0x00 versus 0xFF must not wrap into a match.
      cur_x = 16'h0012;
      cyc(1'b1, 1'b1, 4'b0001);
      cur_x = 16'hFF34;
      idle(12);
      chk("no_wrap_u1", 32'(cnt1), 32'd2);

      // Abort in flight, then alive dropped during HIT.
      cur_x = 16'h1234;
      cyc(1'b1, 1'b1, 4'b0001);
      idle(2);
      cyc(1'b1, 1'b0, 4'b0000);
      idle(12);
      chk("abort_count", 32'(cnt0), 32'd1);
      clr_stats();
      cyc(1'b1, 1'b1, 4'b0001);
      idle(5);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 4'b0000);
      idle(8);
      chk("hit_ignores_alive", 32'(h0_cyc), 32'd3);

      // Simultaneous shots on channels 1 and 3.
      cyc(1'b1, 1'b1, 4'b1010);
      idle(4);
      cyc(1'b1, 1'b1, 4'b0000);
      chk("simul_hit", 32'(hit0), 32'b1010);
      chk("simul_id", 32'(id0), 32'd1);
      chk("simul_any", 32'(any0), 32'd1);
      idle(10);
      chk("simul_count", 32'(cnt0), 32'd4);
      chk("sat_count", 32'(cnt1), 32'd3);

      // Shot request held high: one shot per full channel cycle.
      clr_stats();
      for (int i = 0; i < 44; i++) cyc(1'b1, 1'b1, 4'b0001);
      idle(12);
      chk("held_shots", 32'(rise0), 32'd4);
      chk("held_count", 32'(cnt0), 32'd8);
      chk("held_sat", 32'(cnt1), 32'd3);

      // Reset mid-flight discards the pending shot.
      cyc(1'b1, 1'b1, 4'b0100);
      idle(2);
      clr_stats();
      cyc(1'b0, 1'b1, 4'b0000);
      idle(12);
      chk("rst_flight_count", 32'(cnt0), 32'd0);
      chk("rst_flight_nohit", 32'(anyc), 32'd0);

      // Randomized traffic around the aim point.
      for (int i = 0; i < 3000; i++) begin
         bit       rn, al;
         logic [3:0] sh;
         rn = ($urandom_range(0, 199) != 0);
         al = ($urandom_range(0, 24) != 0);
         sh = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         if ($urandom_range(0, 3) == 0)
            cur_x = {8'(int'(cur_x[15:8]) + $urandom_range(0, 4) - 2), 8'($urandom)};
         if ($urandom_range(0, 5) == 0)
            cur_y = {8'(int'(cur_y[15:8]) + $urandom_range(0, 2) - 1), 8'($urandom)};
         cyc(rn, al, sh);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/arrow_tracker_multi.md
Name: arrow_tracker_multi

Overview:
- Parametrised successor to the single-shooter arrow timer. Tracks up to N_CH independent shooters.
- Per shooter: latches the target's coarse position when the shot fires, waits a flight time, then compares the target's current position against the latched aim within a tolerance.
- On a match, drives a hit pulse followed by an arrow-visible window, then a cooldown.
- Sits between the shooter/player logic and the VGA overlay and health logic. Also keeps a saturating global hit counter.

Parameters:
- N_CH, 4, number of independent shooter channels (1..16)
- COORD_W, 16, width of target position inputs
- CMP_W, 8, number of MSBs of each coordinate used for aim comparison (CMP_W <= COORD_W)
- TOL, 0, allowed absolute difference per axis on the CMP_W-bit values
- FLIGHT_CYC, 15000000, cycles between shot and evaluation (>= 1)
- HIT_CYC, 10000000, cycles the hit flag is held (>= 1)
- SHOW_CYC, 2000000, extra cycles the arrow stays visible after the hit flag drops (>= 1)
- COOL_CYC, 1, cycles a channel stays blocked before accepting a new shot (>= 1)
- CNT_W, 8, width of the global hit counter

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  synchronous active-low reset
- alive  in  1  target alive; low blocks new shots and aborts in-flight shots
- who_shoot  in  N_CH  per-channel shot request, level-sampled
- target_x  in  COORD_W  target x position
- target_y  in  COORD_W  target y position
- arrow  out  N_CH  per-channel arrow-visible flag
- hit  out  N_CH  per-channel hit flag
- any_hit  out  1  OR of hit
- hit_id  out  clog2(N_CH) (min 1)  lowest index with hit=1; 0 when any_hit=0
- busy  out  N_CH  channel not in IDLE
- hit_count  out  CNT_W  saturating count of hit events

Behaviour:
- Reset (Reset_n=0 at a Clk edge):
  - All channels go to IDLE.
  - All counters and latched aims are cleared.
  - arrow, hit, busy, hit_count and hit_id are all 0.
  - Reset mid-operation discards all pending shots with no hit generated.
- Each channel has its own FSM: IDLE, FLIGHT, HIT, SHOW, COOL. Each has its own down-counter cnt, wide enough for the largest *_CYC.
- Aim values: ax = target_x[COORD_W-1 -: CMP_W]; ay likewise from target_y.
- IDLE:
  - If who_shoot[i]=1 and alive=1: latch aim (ax, ay), set cnt=FLIGHT_CYC-1, go to FLIGHT.
  - Otherwise stay in IDLE.
- FLIGHT:
  - If alive=0: go to IDLE immediately. No evaluation, no hit.
  - Else if cnt=0: evaluate using the current target position. A match requires both |ax_now-aim_x| <= TOL and |ay_now-aim_y| <= TOL, computed as unsigned differences with no wrap-around.
    - Match: go to HIT with cnt=HIT_CYC-1.
    - No match: go to COOL with cnt=COOL_CYC-1.
  - Else decrement cnt.
- HIT:
  - hit[i]=1 and arrow[i]=1.
  - At cnt=0: go to SHOW with cnt=SHOW_CYC-1.
  - alive is ignored in this state.
- SHOW:
  - arrow[i]=1, hit[i]=0.
  - At cnt=0: go to COOL with cnt=COOL_CYC-1.
- COOL:
  - All outputs 0; busy[i]=1.
  - At cnt=0: go to IDLE.
- Shot requests in any state other than IDLE are ignored (not queued).
- Latency:
  - who_shoot sampled at edge 0; FLIGHT occupies edges 1..FLIGHT_CYC; evaluation happens on the last FLIGHT cycle.
  - hit first high after edge FLIGHT_CYC+1 and stays high for HIT_CYC cycles.
  - arrow stays high for HIT_CYC+SHOW_CYC cycles.
  - Earliest re-fire: a miss blocks the channel for FLIGHT_CYC+COOL_CYC cycles; a hit blocks it for FLIGHT_CYC+HIT_CYC+SHOW_CYC+COOL_CYC cycles.
- Outputs are registered, decoded from the FSM state register. busy[i] = (state != IDLE).
- hit_count:
  - Adds the number of channels entering HIT this cycle (popcount).
  - Saturates at 2^CNT_W-1; never wraps.
  - Multiple channels hitting in the same cycle each count.
- hit_id and any_hit are combinational from the registered hit vector. Lowest index wins.
- Channels are fully independent. Simultaneous shots, evaluations and aborts on different channels do not interact.

Test Plan:
- Single hit (FLIGHT_CYC=4, HIT_CYC=3, SHOW_CYC=2, COOL_CYC=1, TOL=0): target 0x1234/0x5678 held; pulse who_shoot=4'b0001 -> hit[0] high for 3 cycles starting 5 cycles after the shot edge; arrow[0] high for 5 cycles; hit_count=1; hit_id=0; busy[0] low 11 cycles after the shot edge.
- Miss and tolerance:
  - Shoot at x=0x10xx, then move to 0x12xx before evaluation, TOL=1 -> no hit; channel returns to IDLE after 5 cycles.
  - Repeat with 0x11xx -> hit.
  - Difference of 0x00 vs 0xFF -> no hit (no wrap).
- Abort: alive driven 0 during FLIGHT -> channel in IDLE the next cycle, no hit, count unchanged. alive=0 while in HIT -> hit still completes all 3 cycles.
- Simultaneous: who_shoot=4'b1010 on a stationary target -> hit[1] and hit[3] rise in the same cycle; any_hit=1; hit_id=1; hit_count increments by 2.
- Ignored re-fire and saturation:
  - who_shoot held high continuously -> exactly one shot per full channel cycle.
  - CNT_W=2 with 5 hits -> hit_count stops at 3.
- Reset mid-flight: Reset_n=0 for 1 cycle during FLIGHT -> all outputs 0 at the next edge; no later hit appears.
